// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps a 32-bit operand through the ALU's single-bit
// shifter once per cycle until the requested shift amount has been consumed.
module shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_operand,
    input  logic [4:0]  in_shamt,
    output logic [31:0] alu_rs1_data,
    output logic [2:0]  alu_ctrl,
    output logic        alu_num2_sel,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready/valid are decoded from state only, so neither depends on the other side's signals.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] work, work_nxt;
    logic [4:0]  count, count_nxt;
    logic [1:0]  op_q, op_nxt;
    logic        err_q, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
            op_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            count <= count_nxt;
            op_q  <= op_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        count_nxt = count;
        op_nxt    = op_q;
        err_nxt   = err_q;
        if (flush) begin
            // Abort leaves the datapath registers untouched; only the state returns home.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_nxt  = in_operand;
                        count_nxt = in_shamt;
                        op_nxt    = in_op;
                        err_nxt   = (in_op == 2'b11);
                        state_nxt = (in_shamt == 5'd0 || in_op == 2'b11) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    work_nxt  = alu_result;
                    count_nxt = count - 5'd1;
                    if (count == 5'd1) state_nxt = DONE;
                end
                DONE: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        alu_ctrl = 3'd0;
        if (state == SHIFT) begin
            case (op_q)
                2'b00:   alu_ctrl = 3'd5;
                2'b01:   alu_ctrl = 3'd6;
                2'b10:   alu_ctrl = 3'd7;
                default: alu_ctrl = 3'd0;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign alu_rs1_data = work;
    assign alu_num2_sel = 1'b0;
    assign out_data     = work;
    assign out_err      = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural single-bit ALU, vector table plus
// hand-written reset, backpressure and flush sequences, scoreboard of expected results.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_operand;
    logic [4:0]  in_shamt;
    logic [31:0] alu_rs1_data;
    logic [2:0]  alu_ctrl;
    logic        alu_num2_sel;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    shift_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_operand   (in_operand),
        .in_shamt     (in_shamt),
        .alu_rs1_data (alu_rs1_data),
        .alu_ctrl     (alu_ctrl),
        .alu_num2_sel (alu_num2_sel),
        .alu_result   (alu_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err),
        .busy         (busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Single-bit ALU shifter seen by the block
    always_comb begin
        case (alu_ctrl)
            3'd5:    alu_result = alu_rs1_data << 1;
            3'd6:    alu_result = alu_rs1_data >> 1;
            3'd7:    alu_result = $unsigned($signed(alu_rs1_data) >>> 1);
            default: alu_result = alu_rs1_data;
        endcase
    end

    function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] v, logic [4:0] sh);
        case (op)
            2'b00:   return v << sh;
            2'b01:   return v >> sh;
            2'b10:   return $unsigned($signed(v) >>> sh);
            default: return v;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: entered just after a negedge; returns at the negedge of cycle c0+1.
    task automatic drive_req(input logic [1:0] op, input logic [31:0] v, input logic [4:0] sh,
                             input logic [31:0] exp_data, input logic exp_err);
        chk("in_ready_before_req", {63'd0, in_ready}, 64'd1);
        in_valid   = 1'b1;
        in_op      = op;
        in_operand = v;
        in_shamt   = sh;
        exp_q.push_back({exp_err, exp_data});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for the result, checks latency/shift cycles, holds off out_ready for `hold` cycles.
    task automatic wait_result(input logic [1:0] op, input logic [4:0] sh, input int hold);
        int          lat;
        int          shifts;
        logic        bad_ctrl;
        logic [2:0]  code;
        logic [32:0] exp;
        int          exp_lat;
        lat      = 1;
        shifts   = 0;
        bad_ctrl = 1'b0;
        code     = (op == 2'b00) ? 3'd5 : (op == 2'b01) ? 3'd6 : 3'd7;
        exp_lat  = (op == 2'b11 || sh == 5'd0) ? 1 : int'(sh) + 1;
        while (!out_valid && lat < 64) begin
            if (alu_ctrl != 3'd0) begin
                shifts++;
                if (alu_ctrl != code) bad_ctrl = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        chk("out_valid_latency", 64'(lat), 64'(exp_lat));
        chk("shift_cycles", 64'(shifts), 64'(exp_lat - 1));
        chk("alu_ctrl_code", {63'd0, bad_ctrl}, 64'd0);
        chk("alu_ctrl_idle_in_done", {61'd0, alu_ctrl}, 64'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_0000;
        chk("out_data", {32'd0, out_data}, {32'd0, exp[31:0]});
        chk("out_err", {63'd0, out_err}, {63'd0, exp[32]});
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_operand = $urandom;
            in_shamt   = 5'($urandom_range(0, 31));
            @(negedge clk);
            chk("hold_valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
            chk("hold_data", {31'd0, out_err, out_data}, {31'd0, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_accept", {61'd0, in_ready, busy, out_valid}, 64'd4);
    endtask

    initial begin
        int      never_valid;
        logic [1:0]  rop;
        logic [31:0] rv;
        logic [4:0]  rsh;

        vecs[0] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[1] = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
        vecs[2] = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
        vecs[3] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b1};
        vecs[5] = '{2'b00, 32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A, 1'b0};
        vecs[6] = '{2'b10, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0};
        vecs[8] = '{2'b10, 32'h4000_0000, 5'd3,  32'h0800_0000, 1'b0};

        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 2'b00;
        in_operand = '0;
        in_shamt   = '0;
        out_ready  = 1'b0;
        #8;
        chk("reset_flags", {59'd0, in_ready, out_valid, out_err, busy, alu_num2_sel}, 64'h10);
        chk("reset_alu_ctrl", {61'd0, alu_ctrl}, 64'd0);
        chk("reset_data", {alu_rs1_data, out_data}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table
        foreach (vecs[i]) begin
            drive_req(vecs[i].op, vecs[i].operand, vecs[i].shamt, vecs[i].exp_data, vecs[i].exp_err);
            wait_result(vecs[i].op, vecs[i].shamt, 0);
        end

        // Random requests checked against the reference shift
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            rv  = $urandom;
            rsh = 5'($urandom_range(0, 31));
            drive_req(rop, rv, rsh, ref_shift(rop, rv, rsh), rop == 2'b11);
            wait_result(rop, rsh, $urandom_range(0, 2));
        end

        // Backpressure: SLL 0x3 by 2, out_ready held low for 10 cycles
        drive_req(2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0);
        wait_result(2'b00, 5'd2, 10);

        // Flush on the third SHIFT cycle, then a fresh request right after
        drive_req(2'b01, 32'hFFFF_FFFF, 5'd20, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_operand = 32'h0000_0055;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        chk("flush_to_idle", {61'd0, in_ready, busy, out_valid}, 64'd4);
        chk("flush_keeps_work", {32'd0, out_data}, 64'h3FFF_FFFF);
        drive_req(2'b01, 32'hF0F0_0000, 5'd5, 32'h0787_8000, 1'b0);
        wait_result(2'b01, 5'd5, 0);

        // Request presented together with flush in IDLE is dropped
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_op      = 2'b00;
        in_operand = 32'h0000_0055;
        in_shamt   = 5'd3;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_blocks_accept", {62'd0, in_ready, busy}, 64'd2);

        // Asynchronous reset mid-SHIFT
        drive_req(2'b00, 32'h0000_0001, 5'd31, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
        chk("async_reset_ctrl", {61'd0, alu_ctrl}, 64'd0);
        chk("async_reset_work", {32'd0, out_data}, 64'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        never_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) never_valid++;
        end
        chk("no_stale_result", 64'(never_valid), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
